// File: rtl/gpio_seq_pkg.sv
// Shared definitions for the GPIO write sequencer: register map, FSM states, table geometry.
// Optional feature macro: GPIO_SEQ_LOOP_EN (enables the CTRL Loop bit).
package gpio_seq_pkg;

    localparam int unsigned TABLE_DEPTH = 8;
    localparam int unsigned IDX_W       = 3;

    localparam logic [3:0] REG_CTRL       = 4'd0;
    localparam logic [3:0] REG_INTERVAL   = 4'd1;
    localparam logic [3:0] REG_TARGET     = 4'd2;
    localparam logic [3:0] REG_STATUS     = 4'd3;
    localparam logic [3:0] REG_TABLE_BASE = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2
    } seq_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/gpio_seq_table.sv
// 8x16 sequence table: one write port, combinational host and sequencer read ports.
// Contents are intentionally not reset.
module gpio_seq_table
    import gpio_seq_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [15:0]      wdata,
    input  logic [IDX_W-1:0] haddr,
    output logic [15:0]      hdata,
    input  logic [IDX_W-1:0] saddr,
    output logic [15:0]      sdata
);

    logic [15:0] mem [TABLE_DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign hdata = mem[haddr];
    assign sdata = mem[saddr];

endmodule

// File: rtl/gpio_seq_arb.sv
// GPIO port arbiter: host accesses pass straight through; a timed sequencer replays TABLE writes
// to TARGET when the host is quiet. Optional macro GPIO_SEQ_LOOP_EN enables CTRL.Loop.
module gpio_seq_arb
    import gpio_seq_pkg::*;
(
    input  logic        Clk,
    input  logic        ResetN,
    input  logic [3:0]  HostAddr,
    input  logic [15:0] HostDataWr,
    input  logic        HostEn,
    input  logic        SeqEn,
    input  logic        HostRd,
    input  logic        HostWr,
    output logic [15:0] HostDataRd,
    output logic [3:0]  GAddr,
    output logic [15:0] GDataWr,
    output logic        GEn,
    output logic        GRd,
    output logic        GWr,
    input  logic [15:0] GDataRd,
    output logic        Done
);

    seq_state_t       state;
    logic             run;
    logic             loop;
    logic [2:0]       last;
    logic [IDX_W-1:0] index;
    logic [15:0]      interval;
    logic [15:0]      cnt;
    logic [3:0]       target;
    logic [7:0]       defer;
    logic             busy;

    logic             host_acc;
    logic             seq_wr;
    logic             ctrl_wr;
    logic             abort;
    logic             issue;
    logic [15:0]      tbl_host;
    logic [15:0]      tbl_seq;
    logic [15:0]      seq_rdata;

    assign host_acc = HostEn & (HostRd | HostWr);
    assign seq_wr   = SeqEn & HostWr;
    assign ctrl_wr  = seq_wr & (HostAddr == REG_CTRL);
    assign abort    = ctrl_wr & ~HostDataWr[0];
    // A Run=0 write suppresses the issue in its own cycle, same as a host access.
    assign issue    = (state == ST_ISSUE) & ~host_acc & ~abort;
    assign busy     = (state != ST_IDLE);

    gpio_seq_table u_table (
        .clk   (Clk),
        .we    (seq_wr & (HostAddr >= REG_TABLE_BASE)),
        .waddr (HostAddr[IDX_W-1:0]),
        .wdata (HostDataWr),
        .haddr (HostAddr[IDX_W-1:0]),
        .hdata (tbl_host),
        .saddr (index),
        .sdata (tbl_seq)
    );

`ifdef GPIO_SEQ_LOOP_EN
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN)      loop <= 1'b0;
        else if (ctrl_wr) loop <= HostDataWr[1];
    end
`else
    assign loop = 1'b0;
`endif

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state    <= ST_IDLE;
            run      <= 1'b0;
            last     <= '0;
            interval <= '0;
            target   <= '0;
            index    <= '0;
            cnt      <= '0;
            defer    <= '0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (seq_wr && HostAddr == REG_INTERVAL) interval <= HostDataWr;
            if (seq_wr && HostAddr == REG_TARGET)   target   <= HostDataWr[3:0];
            if (ctrl_wr)                            last     <= HostDataWr[6:4];
            if (seq_wr && HostAddr == REG_STATUS)
                defer <= '0;
            else if (state == ST_ISSUE && host_acc && !abort)
                defer <= sat_inc8(defer);

            if (abort) begin
                run   <= 1'b0;
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ctrl_wr && HostDataWr[0]) begin
                            run   <= 1'b1;
                            index <= '0;
                            cnt   <= interval;
                            state <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (cnt == '0) state <= ST_ISSUE;
                        else           cnt   <= cnt - 16'd1;
                    end
                    ST_ISSUE: begin
                        if (issue) begin
                            if (index != last) begin
                                index <= index + 3'd1;
                                cnt   <= interval;
                                state <= ST_WAIT;
                            end else if (loop) begin
                                index <= '0;
                                cnt   <= interval;
                                state <= ST_WAIT;
                            end else begin
                                run   <= 1'b0;
                                Done  <= 1'b1;
                                state <= ST_IDLE;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        seq_rdata = '0;
        if (HostAddr >= REG_TABLE_BASE) begin
            seq_rdata = tbl_host;
        end else begin
            case (HostAddr)
                REG_CTRL:     seq_rdata = {9'b0, last, 2'b0, loop, run};
                REG_INTERVAL: seq_rdata = interval;
                REG_TARGET:   seq_rdata = {12'b0, target};
                REG_STATUS:   seq_rdata = {defer, 1'b0, index, 3'b0, busy};
                default:      seq_rdata = '0;
            endcase
        end
    end

    always_comb begin
        HostDataRd = '0;
        if (HostEn)     HostDataRd = GDataRd;
        else if (SeqEn) HostDataRd = seq_rdata;
    end

    always_comb begin
        GAddr   = '0;
        GDataWr = '0;
        GEn     = 1'b0;
        GRd     = 1'b0;
        GWr     = 1'b0;
        if (host_acc) begin
            GAddr   = HostAddr;
            GDataWr = HostDataWr;
            GEn     = 1'b1;
            GRd     = HostRd;
            GWr     = HostWr;
        end else if (issue) begin
            GAddr   = target;
            GDataWr = tbl_seq;
            GEn     = 1'b1;
            GWr     = 1'b1;
        end
    end

endmodule

// File: tb/tb_gpio_seq_arb.sv
// Scoreboard bench for gpio_seq_arb: directed stimulus pushes expected G-port, Done and read
// events; a negedge monitor pops and compares them whenever the DUT presents one.
module tb_gpio_seq_arb;

    logic        Clk = 1'b0;
    logic        ResetN = 1'b0;
    logic [3:0]  HostAddr;
    logic [15:0] HostDataWr;
    logic        HostEn, SeqEn, HostRd, HostWr;
    logic [15:0] HostDataRd;
    logic [3:0]  GAddr;
    logic [15:0] GDataWr;
    logic        GEn, GRd, GWr;
    logic [15:0] GDataRd;
    logic        Done;

    typedef struct {
        int          cyc;
        logic [3:0]  addr;
        logic [15:0] data;
        logic        rd;
        logic        wr;
    } gev_t;

    gev_t        gq[$];
    int          dq[$];
    logic [15:0] rq[$];
    gev_t        mg;
    int          md;
    logic [15:0] mr;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    gpio_seq_arb dut (
        .Clk        (Clk),
        .ResetN     (ResetN),
        .HostAddr   (HostAddr),
        .HostDataWr (HostDataWr),
        .HostEn     (HostEn),
        .SeqEn      (SeqEn),
        .HostRd     (HostRd),
        .HostWr     (HostWr),
        .HostDataRd (HostDataRd),
        .GAddr      (GAddr),
        .GDataWr    (GDataWr),
        .GEn        (GEn),
        .GRd        (GRd),
        .GWr        (GWr),
        .GDataRd    (GDataRd),
        .Done       (Done)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc++;

    // Simple GPIO block model: read data identifies the address.
    assign GDataRd = {12'hA50, GAddr};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: unexpected event at cycle %0d (GAddr=%0h GDataWr=%0h GRd=%0b GWr=%0b Done=%0b)",
                 name, cyc, GAddr, GDataWr, GRd, GWr, Done);
    endtask

    always @(negedge Clk) begin
        if (GEn) begin
            if (gq.size() == 0) unexpected("gport");
            else begin
                mg = gq.pop_front();
                check("gport{cyc,addr,data,rd,wr}", {cyc, GAddr, GDataWr, GRd, GWr},
                      {mg.cyc, mg.addr, mg.data, mg.rd, mg.wr});
            end
        end
        if (Done) begin
            if (dq.size() == 0) unexpected("done");
            else begin
                md = dq.pop_front();
                check("done_cycle", cyc, md);
            end
        end
        if (HostRd && (HostEn || SeqEn)) begin
            if (rq.size() == 0) unexpected("readdata");
            else begin
                mr = rq.pop_front();
                check("readdata", HostDataRd, mr);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic bus_idle();
        HostEn = 1'b0; SeqEn = 1'b0; HostRd = 1'b0; HostWr = 1'b0;
        HostAddr = '0; HostDataWr = '0;
    endtask

    task automatic exp_g(input int c, input logic [3:0] a, input logic [15:0] d,
                         input logic rd, input logic wr);
        gev_t e;
        e.cyc = c; e.addr = a; e.data = d; e.rd = rd; e.wr = wr;
        gq.push_back(e);
    endtask

    task automatic seq_write(input logic [3:0] a, input logic [15:0] d);
        SeqEn = 1'b1; HostWr = 1'b1; HostAddr = a; HostDataWr = d;
        tick();
        bus_idle();
    endtask

    task automatic seq_read(input logic [3:0] a, input logic [15:0] exp);
        rq.push_back(exp);
        SeqEn = 1'b1; HostRd = 1'b1; HostAddr = a;
        tick();
        bus_idle();
    endtask

    task automatic host_write(input logic [3:0] a, input logic [15:0] d, input int n);
        HostEn = 1'b1; HostWr = 1'b1; HostAddr = a; HostDataWr = d;
        repeat (n) tick();
        bus_idle();
    endtask

    task automatic host_read(input logic [3:0] a, input logic [15:0] d, input logic [15:0] exp);
        rq.push_back(exp);
        HostEn = 1'b1; HostRd = 1'b1; HostAddr = a; HostDataWr = d;
        tick();
        bus_idle();
    endtask

    initial begin
        int c;
        bus_idle();
        ResetN = 1'b0;
        repeat (3) tick();
        check("reset_outputs", {GEn, GRd, GWr, GAddr, GDataWr, Done, HostDataRd}, '0);
        ResetN = 1'b1;
        tick();

        seq_read(4'd3, 16'h0000);
        seq_read(4'd0, 16'h0000);
        seq_read(4'd1, 16'h0000);
        seq_read(4'd2, 16'h0000);

        // Host read forwarded to the G port, read data from the GPIO model
        exp_g(cyc, 4'h7, 16'h00CC, 1'b1, 1'b0);
        host_read(4'h7, 16'h00CC, 16'hA507);

        seq_write(4'd8, 16'd1);
        seq_write(4'd9, 16'd2);
        seq_write(4'd10, 16'd3);
        seq_write(4'd2, 16'd4);
        seq_write(4'd1, 16'd3);
        seq_read(4'd9, 16'd2);
        seq_read(4'd2, 16'd4);

        // One-shot sequence, INTERVAL=3, Last=2
        c = cyc;
        exp_g(c + 5, 4'd4, 16'd1, 1'b0, 1'b1);
        exp_g(c + 10, 4'd4, 16'd2, 1'b0, 1'b1);
        exp_g(c + 15, 4'd4, 16'd3, 1'b0, 1'b1);
        dq.push_back(c + 16);
        seq_write(4'd0, 16'h0021);
        seq_read(4'd3, 16'h0001);
        wait_until(c + 20);
        seq_read(4'd3, 16'h0020);
        seq_read(4'd0, 16'h0020);

        // Host write held 3 cycles across ISSUE defers the first sequencer write
        c = cyc;
        exp_g(c + 5, 4'hA, 16'hBEEF, 1'b0, 1'b1);
        exp_g(c + 6, 4'hA, 16'hBEEF, 1'b0, 1'b1);
        exp_g(c + 7, 4'hA, 16'hBEEF, 1'b0, 1'b1);
        exp_g(c + 8, 4'd4, 16'd1, 1'b0, 1'b1);
        exp_g(c + 13, 4'd4, 16'd2, 1'b0, 1'b1);
        exp_g(c + 18, 4'd4, 16'd3, 1'b0, 1'b1);
        dq.push_back(c + 19);
        seq_write(4'd0, 16'h0021);
        wait_until(c + 5);
        host_write(4'hA, 16'hBEEF, 3);
        wait_until(c + 22);
        seq_read(4'd3, 16'h0320);
        seq_write(4'd3, 16'h1234);
        seq_read(4'd3, 16'h0020);

        // INTERVAL=0: issues every 2 cycles
        seq_write(4'd1, 16'd0);
        c = cyc;
        exp_g(c + 2, 4'd4, 16'd1, 1'b0, 1'b1);
        exp_g(c + 4, 4'd4, 16'd2, 1'b0, 1'b1);
        exp_g(c + 6, 4'd4, 16'd3, 1'b0, 1'b1);
        dq.push_back(c + 7);
        seq_write(4'd0, 16'h0021);
        wait_until(c + 10);

        // 260 cycles of contention saturate Defer at 255
        c = cyc;
        for (int i = 2; i < 262; i++) exp_g(c + i, 4'd5, 16'h1234, 1'b0, 1'b1);
        exp_g(c + 262, 4'd4, 16'd1, 1'b0, 1'b1);
        exp_g(c + 264, 4'd4, 16'd2, 1'b0, 1'b1);
        exp_g(c + 266, 4'd4, 16'd3, 1'b0, 1'b1);
        dq.push_back(c + 267);
        seq_write(4'd0, 16'h0021);
        wait_until(c + 2);
        host_write(4'd5, 16'h1234, 260);
        wait_until(c + 270);
        seq_read(4'd3, 16'hFF20);
        seq_write(4'd3, 16'h0000);
        seq_read(4'd3, 16'h0020);

        seq_write(4'd1, 16'd3);
        c = cyc;
`ifdef GPIO_SEQ_LOOP_EN
        // Looping sequence aborted by a Run=0 write landing in an ISSUE cycle
        exp_g(c + 5, 4'd4, 16'd1, 1'b0, 1'b1);
        exp_g(c + 10, 4'd4, 16'd2, 1'b0, 1'b1);
        exp_g(c + 15, 4'd4, 16'd3, 1'b0, 1'b1);
        exp_g(c + 20, 4'd4, 16'd1, 1'b0, 1'b1);
        exp_g(c + 25, 4'd4, 16'd2, 1'b0, 1'b1);
        seq_write(4'd0, 16'h0023);
        seq_read(4'd0, 16'h0023);
        wait_until(c + 30);
        seq_write(4'd0, 16'h0000);
        wait_until(c + 45);
        seq_read(4'd3, 16'h0020);
        seq_read(4'd0, 16'h0000);
`else
        // Build without looping: CTRL bit1 reads 0, sequence terminates after Last
        exp_g(c + 5, 4'd4, 16'd1, 1'b0, 1'b1);
        exp_g(c + 10, 4'd4, 16'd2, 1'b0, 1'b1);
        exp_g(c + 15, 4'd4, 16'd3, 1'b0, 1'b1);
        dq.push_back(c + 16);
        seq_write(4'd0, 16'h0023);
        seq_read(4'd0, 16'h0021);
        wait_until(c + 30);
        seq_read(4'd3, 16'h0020);
        seq_read(4'd0, 16'h0020);
`endif

        // Reset during WAIT: no further issue, registers cleared, table kept
        c = cyc;
        seq_write(4'd0, 16'h0021);
        wait_until(c + 2);
        ResetN = 1'b0;
        #2;
        check("reset_midseq_outputs", {GEn, GRd, GWr, GAddr, GDataWr, Done, HostDataRd}, '0);
        wait_until(c + 4);
        ResetN = 1'b1;
        seq_read(4'd3, 16'h0000);
        seq_read(4'd0, 16'h0000);
        seq_read(4'd1, 16'h0000);
        seq_read(4'd2, 16'h0000);
        seq_read(4'd8, 16'd1);
        seq_read(4'd9, 16'd2);
        seq_read(4'd10, 16'd3);
        wait_until(c + 25);

        while (gq.size() > 0) begin
            mg = gq.pop_front();
            vectors++; miscompares++;
            $display("FAIL gport_missing: expected access at cycle %0d addr=%0h data=%0h never seen",
                     mg.cyc, mg.addr, mg.data);
        end
        while (dq.size() > 0) begin
            md = dq.pop_front();
            vectors++; miscompares++;
            $display("FAIL done_missing: expected Done at cycle %0d never seen", md);
        end
        while (rq.size() > 0) begin
            mr = rq.pop_front();
            vectors++; miscompares++;
            $display("FAIL read_missing: expected read data %0h never compared", mr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
